decode_stage_hz: RTL and testbench
==================================

# decode_stage_hz

Parametrised ID stage with hazard hooks for the 5-stage RISC-V core: decodes `InstrD`, reads the integrated register file, extends immediates and registers everything into the ID/EX pipeline register. Over the first-generation decode stage it adds:

- width and register-count parameters;
- write-through bypass from WB;
- stall and flush controls;
- Rs1/Rs2 export for the hazard unit;
- an illegal-instruction flag.

It sits between the fetch stage (IF/ID register) and the execute stage.

## Interface
- `XLEN`, 32, datapath width (32 only for RV32I decode; width of PC/data buses)
- `NREG`, 32, architectural registers; index width `RW = $clog2(NREG)`
- `clk  in  1`  rising-edge clock
- `rst  in  1`  reset; one clock; reset is asynchronous and active-high
- `InstrD  in  32`  instruction from IF/ID
- `PCD, PCPlus4D  in  XLEN`  PC and PC+4 from IF/ID
- `RegWriteW  in  1`  WB write enable
- `RdW  in  RW`  WB destination
- `ResultW  in  XLEN`  WB data
- `StallE  in  1`  hold ID/EX register contents
- `FlushE  in  1`  insert bubble into ID/EX
- `RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1`  registered controls
- `ResultSrcE  out  2`  00 ALU, 01 memory, 10 PC+4
- `ALUControlE  out  3`  000 add, 001 sub, 010 and, 011 or, 101 slt
- `RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN`  registered operands
- `Rs1E, Rs2E, RdE  out  RW`  registered register indices
- `Rs1D, Rs2D  out  RW`  combinational `InstrD[19:15]`, `InstrD[24:20]` for load-use detection
- `IllegalE  out  1`  registered: unsupported opcode/funct

## Operation
- **Supported instructions:**
  - R-type (0110011): add/sub/and/or/slt
  - I-ALU (0010011): addi/andi/ori/slti
  - lw (0000011)
  - sw (0100011)
  - beq (1100011)
  - jal (1101111)
- **Anything else:** all control outputs 0 and `IllegalE=1`. The instruction is still registered.
- **ALU decode:**
  - add/sub for R-type is selected by `funct7[5]`; I-type never subtracts.
  - lw/sw use add; beq uses sub.
- **Immediate extension:** sign-extended to XLEN.
  - I: `[31:20]`
  - S: `{[31:25],[11:7]}`
  - B: `{[31],[7],[30:25],[11:8],0}`
  - J: `{[31],[19:12],[20],[30:21],0}`
- **Register file:** NREG×XLEN, 2 async read ports, 1 write port written on the rising edge when `RegWriteW && RdW!=0`.
  - x0 reads 0 always.
  - On `rst` all entries clear to 0.
- **Write-through bypass:** if `RegWriteW && RdW==Rs1D && RdW!=0`, the read port returns `ResultW` in the same cycle. Port 2 behaves the same way.
- **ID/EX register priority** (rising edge):
  1. `rst`
  2. `FlushE`
  3. `StallE`
  4. load
- **Flush:** clears all control outputs and `IllegalE` to 0, and clears `RdE/Rs1E/Rs2E` to 0. Data fields are don't-care (implemented as 0).
- **Stall:** holds every E output. The register file still accepts the WB write.

## Timing
- **Latency:** 1 cycle, InstrD→E outputs. `Rs1D/Rs2D` are combinational (0 cycles).
- **Reset:** asynchronous assert, every E output is 0 immediately; the register file is zeroed. Deassertion is synchronous to `clk` by the top level.
- **Reset mid-operation:** pending data is lost; the first valid edge after deassert loads `InstrD`.
- **Simultaneous events:**
  - `FlushE` and `StallE` together → flush.
  - WB write to the same register being read → new value is captured into `RD1E/RD2E` on that edge.
  - WB to x0 → ignored; reads 0.

## Structure
- **Package `riscv_pkg`:**
  - opcode localparams (`OP_R`, `OP_I`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_JAL`)
  - ALU control encodings
  - `ResultSrc` encodings
  - `ImmSrc` encodings (I=00, S=01, B=10, J=11)
- **Sub-modules:**
  - `reg_file #(XLEN,NREG)`: holds the storage and bypass.
  - Control decode and immediate extend stay inline as combinational blocks.

## Test plan
- **Reset:** rst=1 for 3 cycles → all E outputs 0; `RD1E` of x5 afterwards reads 0.
- **Write then decode:**
  - Stimulus: WB writes x5=0x0000_00F0 and x6=0x0000_0F0F. Next cycle `InstrD=0x0062F433` (and x8,x5,x6).
  - Expected after 1 edge: `RegWriteE=1`, `ALUControlE=010`, `ALUSrcE=0`, `ResultSrcE=00`, `RD1E=0xF0`, `RD2E=0xF0F`, `RdE=8`, `Rs1E=5`, `Rs2E=6`.
- **Bypass:**
  - Stimulus: same cycle as decode of 0x0062F433, `RegWriteW=1`, `RdW=6`, `ResultW=0x1234`.
  - Expected: `RD2E=0x1234`. With `RdW=0`, the write is ignored.
- **Immediates:**
  - Stimulus: `lw x1,-4(x2)` (0xFFC12083).
  - Expected: `ImmExtE=0xFFFF_FFFC`, `ResultSrcE=01`, `ALUSrcE=1`.
  - Stimulus: `jal x1,+8` (0x008000EF).
  - Expected: `ImmExtE=8`, `JumpE=1`, `ResultSrcE=10`.
- **Stall/flush:**
  - Stimulus: `StallE=1` while `InstrD` changes.
  - Expected: E outputs unchanged.
  - Stimulus: `FlushE=1` together with `StallE=1`.
  - Expected: controls, `RdE`, `IllegalE` all 0.
- **Illegal:**
  - Stimulus: `InstrD=0xFFFFFFFF`.
  - Expected: `IllegalE=1`, `RegWriteE=MemWriteE=JumpE=BranchE=0`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared decode constants and the control bundle carried through ID/EX.
package riscv_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two async read ports with WB write-through, one write port.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NREG)-1:0] ra1_i,
  input  logic [$clog2(NREG)-1:0] ra2_i,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] wa_i,
  input  logic [XLEN-1:0]         wd_i,
  output logic [XLEN-1:0]         rd1_o,
  output logic [XLEN-1:0]         rd2_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_en;

  assign wr_en = we_i && (wa_i != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Bypass lets the ID/EX register capture a value being written back on the same edge.
  always_comb begin
    rd1_o = regs_q[ra1_i];
    if (ra1_i == '0)                   rd1_o = '0;
    else if (wr_en && (wa_i == ra1_i)) rd1_o = wd_i;
  end

  always_comb begin
    rd2_o = regs_q[ra2_i];
    if (ra2_i == '0)                   rd2_o = '0;
    else if (wr_en && (wa_i == ra2_i)) rd2_o = wd_i;
  end

endmodule

// File: rtl/decode_stage_hz.sv
// RV32I ID stage: control decode, register read with WB bypass, immediate extend,
// and the ID/EX pipeline register with flush/stall.
import riscv_pkg::*;

module decode_stage_hz #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [RW-1:0]   RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallE,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [RW-1:0]   Rs1E,
  output logic [RW-1:0]   Rs2E,
  output logic [RW-1:0]   RdE,
  output logic [RW-1:0]   Rs1D,
  output logic [RW-1:0]   Rs2D,
  output logic            IllegalE
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RW-1:0]   rd_d;
  logic [1:0]      imm_src;
  logic            legal;
  ctrl_t           ctrl_d, ctrl_q;
  logic [XLEN-1:0] rd1_d, rd2_d, imm_d;
  logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q, pc4_q;
  logic [RW-1:0]   rs1_q, rs2_q, rd_q;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];
  assign Rs1D   = InstrD[15 +: RW];
  assign Rs2D   = InstrD[20 +: RW];
  assign rd_d   = InstrD[7 +: RW];

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (Rs1D),
    .ra2_i (Rs2D),
    .we_i  (RegWriteW),
    .wa_i  (RdW),
    .wd_i  (ResultW),
    .rd1_o (rd1_d),
    .rd2_o (rd2_d)
  );

  always_comb begin
    ctrl_d  = '0;
    imm_src = IMM_I;
    legal   = 1'b1;
    case (opcode)
      OP_R: begin
        ctrl_d.reg_write = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'h00)      ctrl_d.alu_control = ALU_ADD;
            else if (funct7 == 7'h20) ctrl_d.alu_control = ALU_SUB;
            else                      legal = 1'b0;
          end
          3'b111: begin ctrl_d.alu_control = ALU_AND; legal = (funct7 == 7'h00); end
          3'b110: begin ctrl_d.alu_control = ALU_OR;  legal = (funct7 == 7'h00); end
          3'b010: begin ctrl_d.alu_control = ALU_SLT; legal = (funct7 == 7'h00); end
          default: legal = 1'b0;
        endcase
      end
      OP_I: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        case (funct3)
          3'b000:  ctrl_d.alu_control = ALU_ADD;
          3'b111:  ctrl_d.alu_control = ALU_AND;
          3'b110:  ctrl_d.alu_control = ALU_OR;
          3'b010:  ctrl_d.alu_control = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
      OP_LW: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_MEM;
        legal             = (funct3 == 3'b010);
      end
      OP_SW: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_src          = IMM_S;
        legal            = (funct3 == 3'b010);
      end
      OP_BEQ: begin
        ctrl_d.branch      = 1'b1;
        ctrl_d.alu_control = ALU_SUB;
        imm_src            = IMM_B;
        legal              = (funct3 == 3'b000);
      end
      OP_JAL: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.jump       = 1'b1;
        ctrl_d.result_src = RES_PC4;
        imm_src           = IMM_J;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      ctrl_d         = '0;
      ctrl_d.illegal = 1'b1;
    end
  end

  always_comb begin
    imm_d = '0;
    case (imm_src)
      IMM_I: imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm_d = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                      InstrD[11:8], 1'b0};
      IMM_J: imm_d = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                      InstrD[30:21], 1'b0};
      default: imm_d = '0;
    endcase
  end

  // Flush wins over stall so a bubble can be forced into a held stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      pc4_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
    end else if (FlushE) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      pc4_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
    end else if (!StallE) begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      pc_q   <= PCD;
      pc4_q  <= PCPlus4D;
      rs1_q  <= Rs1D;
      rs2_q  <= Rs2D;
      rd_q   <= rd_d;
    end
  end

  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ctrl_q.alu_control;
  assign IllegalE    = ctrl_q.illegal;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign ImmExtE     = imm_q;
  assign PCE         = pc_q;
  assign PCPlus4E    = pc4_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rd_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Scoreboard bench for decode_stage_hz: directed instructions with hand-computed ID/EX contents.
module tb_decode_stage_hz;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, StallE, FlushE;
  logic [4:0]  RdW;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE, Rs1D, Rs2D;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_hz #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .StallE(StallE), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D), .IllegalE(IllegalE)
  );

  typedef struct {
    string       name;
    logic        rw, mw, j, b, as, ill;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    bit          chk_imm, chk_data;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t e(string n, logic rw, logic mw, logic j, logic b, logic as,
                             logic [1:0] rs, logic [2:0] alu, logic ill,
                             logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                             logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                             logic [31:0] pc, bit chk_imm, bit chk_data);
    exp_t x;
    x.name = n; x.rw = rw; x.mw = mw; x.j = j; x.b = b; x.as = as; x.rs = rs;
    x.alu = alu; x.ill = ill; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.rd1 = rd1;
    x.rd2 = rd2; x.imm = imm; x.pc = pc; x.pc4 = pc + 32'd4;
    x.chk_imm = chk_imm; x.chk_data = chk_data;
    return x;
  endfunction

  task automatic cmp(string t, string f, logic [31:0] act, logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", t, f, act, ex);
    end
  endtask

  task automatic step(logic [31:0] instr, logic [31:0] pc, logic we, logic [4:0] rdw,
                      logic [31:0] res, logic stall, logic flush, bit chk, exp_t ex);
    @(negedge clk);
    rst = 1'b0; InstrD = instr; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = we; RdW = rdw; ResultW = res; StallE = stall; FlushE = flush;
    if (chk) sb.push_back(ex);
  endtask

  // Monitor: every posedge that follows a pushed expectation, compare the ID/EX outputs.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        cmp(x.name, "RegWriteE",   RegWriteE,   x.rw);
        cmp(x.name, "MemWriteE",   MemWriteE,   x.mw);
        cmp(x.name, "JumpE",       JumpE,       x.j);
        cmp(x.name, "BranchE",     BranchE,     x.b);
        cmp(x.name, "ALUSrcE",     ALUSrcE,     x.as);
        cmp(x.name, "ResultSrcE",  ResultSrcE,  x.rs);
        cmp(x.name, "ALUControlE", ALUControlE, x.alu);
        cmp(x.name, "IllegalE",    IllegalE,    x.ill);
        cmp(x.name, "Rs1E",        Rs1E,        x.rs1);
        cmp(x.name, "Rs2E",        Rs2E,        x.rs2);
        cmp(x.name, "RdE",         RdE,         x.rd);
        if (x.chk_imm) cmp(x.name, "ImmExtE", ImmExtE, x.imm);
        if (x.chk_data) begin
          cmp(x.name, "RD1E",     RD1E,     x.rd1);
          cmp(x.name, "RD2E",     RD2E,     x.rd2);
          cmp(x.name, "PCE",      PCE,      x.pc);
          cmp(x.name, "PCPlus4E", PCPlus4E, x.pc4);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t z, none, hold;
    rst = 1'b1; InstrD = 32'h0; PCD = 32'h0; PCPlus4D = 32'h0;
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0; StallE = 1'b0; FlushE = 1'b0;
    z = e("reset", 0,0,0,0,0, 2'b00, 3'b000, 0, 0,0,0, 0,0,0, 32'h0, 1, 1);
    z.pc4 = 32'h0;
    none = z;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sb.push_back(z);
    end

    // x5 read right after reset must be 0
    step(32'h0062F433, 32'h100, 0, 5'd0, 32'h0, 0, 0, 1,
         e("and_post_rst", 1,0,0,0,0, 2'b00, 3'b010, 0, 5,6,8, 32'h0, 32'h0, 0, 32'h100, 0, 1));
    step(32'h00000013, 32'h104, 1, 5'd5, 32'h000000F0, 0, 0, 0, none);
    step(32'h00000013, 32'h108, 1, 5'd6, 32'h00000F0F, 0, 0, 0, none);
    step(32'h0062F433, 32'h200, 0, 5'd0, 32'h0, 0, 0, 1,
         e("and_x5_x6", 1,0,0,0,0, 2'b00, 3'b010, 0, 5,6,8, 32'hF0, 32'hF0F, 0, 32'h200, 0, 1));
    step(32'h0062F433, 32'h204, 1, 5'd6, 32'h00001234, 0, 0, 1,
         e("bypass_rd2", 1,0,0,0,0, 2'b00, 3'b010, 0, 5,6,8, 32'hF0, 32'h1234, 0, 32'h204, 0, 1));
    step(32'h0062F433, 32'h208, 0, 5'd0, 32'h0, 0, 0, 1,
         e("after_bypass", 1,0,0,0,0, 2'b00, 3'b010, 0, 5,6,8, 32'hF0, 32'h1234, 0, 32'h208, 0, 1));
    step(32'h00006433, 32'h20C, 1, 5'd0, 32'h0000DEAD, 0, 0, 1,
         e("or_x0_wb0", 1,0,0,0,0, 2'b00, 3'b011, 0, 0,0,8, 32'h0, 32'h0, 0, 32'h20C, 0, 1));
    step(32'hFFC12083, 32'h210, 0, 5'd0, 32'h0, 0, 0, 1,
         e("lw", 1,0,0,0,1, 2'b01, 3'b000, 0, 2,28,1, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h210, 1, 1));
    #1;
    cmp("lw_comb", "Rs1D", Rs1D, 5'd2);
    cmp("lw_comb", "Rs2D", Rs2D, 5'd28);
    step(32'h008000EF, 32'h214, 0, 5'd0, 32'h0, 0, 0, 1,
         e("jal", 1,0,1,0,0, 2'b10, 3'b000, 0, 0,8,1, 32'h0, 32'h0, 32'h8, 32'h214, 1, 1));
    step(32'h0062A623, 32'h218, 0, 5'd0, 32'h0, 0, 0, 1,
         e("sw", 0,1,0,0,1, 2'b00, 3'b000, 0, 5,6,12, 32'hF0, 32'h1234, 32'd12, 32'h218, 1, 1));
    step(32'hFE628CE3, 32'h21C, 0, 5'd0, 32'h0, 0, 0, 1,
         e("beq", 0,0,0,1,0, 2'b00, 3'b001, 0, 5,6,25, 32'hF0, 32'h1234, 32'hFFFFFFF8, 32'h21C, 1, 1));
    step(32'h406284B3, 32'h220, 0, 5'd0, 32'h0, 0, 0, 1,
         e("sub", 1,0,0,0,0, 2'b00, 3'b001, 0, 5,6,9, 32'hF0, 32'h1234, 0, 32'h220, 0, 1));
    hold = e("slti", 1,0,0,0,1, 2'b00, 3'b101, 0, 5,31,10, 32'hF0, 32'h0, 32'hFFFFFFFF, 32'h224, 1, 1);
    step(32'hFFF2A513, 32'h224, 0, 5'd0, 32'h0, 0, 0, 1, hold);
    hold.name = "stall_hold";
    step(32'hFFFFFFFF, 32'h228, 1, 5'd7, 32'h00000077, 1, 0, 1, hold);
    step(32'h00038593, 32'h22C, 0, 5'd0, 32'h0, 0, 0, 1,
         e("wb_during_stall", 1,0,0,0,1, 2'b00, 3'b000, 0, 7,0,11, 32'h77, 32'h0, 32'h0, 32'h22C, 1, 1));
    step(32'h0062F433, 32'h230, 0, 5'd0, 32'h0, 1, 1, 1,
         e("flush_over_stall", 0,0,0,0,0, 2'b00, 3'b000, 0, 0,0,0, 0,0,0, 32'h0, 0, 0));
    step(32'hFFFFFFFF, 32'h234, 0, 5'd0, 32'h0, 0, 0, 1,
         e("illegal_ones", 0,0,0,0,0, 2'b00, 3'b000, 1, 31,31,31, 32'h0, 32'h0, 0, 32'h234, 0, 1));
    step(32'h00629433, 32'h238, 0, 5'd0, 32'h0, 0, 0, 1,
         e("illegal_sll", 0,0,0,0,0, 2'b00, 3'b000, 1, 5,6,8, 32'hF0, 32'h1234, 0, 32'h238, 0, 1));

    // asynchronous reset mid-operation: outputs drop before any clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("async_rst", "IllegalE", IllegalE, 1'b0);
    cmp("async_rst", "RdE",      RdE,      5'd0);
    cmp("async_rst", "RD1E",     RD1E,     32'h0);
    sb.push_back(z);
    step(32'h0062F433, 32'h300, 0, 5'd0, 32'h0, 0, 0, 1,
         e("rf_cleared", 1,0,0,0,0, 2'b00, 3'b010, 0, 5,6,8, 32'h0, 32'h0, 0, 32'h300, 0, 1));

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
